weight_update_sequencer: RTL and testbench



---
 rtl/weight_update_sequencer_pkg.sv | 40 ++++
 rtl/weight_update_sequencer_sat_sub_unit.sv | 27 ++
 rtl/weight_update_sequencer.sv | 130 +++++++++++++
 tb/tb_weight_update_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_update_sequencer_pkg.sv
// Shared types and helpers for the gradient-descent weight update sequencer.
// Default geometry, idx width helper and the saturating shift-subtract.
package weight_update_sequencer_pkg;

    localparam int SIZE      = 3;
    localparam int DATA_SIZE = 16;
    localparam int SHIFT_W   = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(SIZE);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        UPDATE,
        DONE
    } state_e;

    function automatic logic [DATA_SIZE-1:0] sat_sub(
        input logic [DATA_SIZE-1:0] w,
        input logic [DATA_SIZE-1:0] d,
        input logic [SHIFT_W-1:0]   lr
    );
        logic signed [DATA_SIZE-1:0] sh;
        logic        [DATA_SIZE:0]   dif;
        logic        [DATA_SIZE-1:0] r;
        sh  = $signed(d) >>> lr;
        dif = {w[DATA_SIZE-1], w} - {sh[DATA_SIZE-1], sh};
        r   = dif[DATA_SIZE-1:0];
        if (dif[DATA_SIZE] != dif[DATA_SIZE-1]) begin
            r = dif[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                               : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_update_sequencer_sat_sub_unit.sv
// Combinational y = sat(a - (b >>> shift)), subtraction one bit wider
// than the operands so overflow shows as a mismatch of the top two bits.
module sat_sub_unit #(
    parameter int data_size = 16,
    parameter int shift_w   = 4
) (
    input  logic [data_size-1:0] a,
    input  logic [data_size-1:0] b,
    input  logic [shift_w-1:0]   shift,
    output logic [data_size-1:0] y
);

    logic signed [data_size-1:0] sh;
    logic        [data_size:0]   dif;

    assign sh  = $signed(b) >>> shift;
    assign dif = {a[data_size-1], a} - {sh[data_size-1], sh};

    always_comb begin
        y = dif[data_size-1:0];
        if (dif[data_size] != dif[data_size-1]) begin
            y = dif[data_size] ? {1'b1, {(data_size-1){1'b0}}}
                               : {1'b0, {(data_size-1){1'b1}}};
        end
    end

endmodule

// File: rtl/weight_update_sequencer.sv
// Sequences one weight update pass: capture diff, walk elements one per
// cycle through a single saturating shift-subtract unit, pulse done.
module weight_update_sequencer
    import weight_update_sequencer_pkg::*;
#(
    parameter int size      = SIZE,
    parameter int data_size = DATA_SIZE,
    parameter int shift_w   = SHIFT_W,
    localparam int idx_w    = idx_width(size)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_en,
    input  logic [size*data_size-1:0] weight_in,
    input  logic [size*data_size-1:0] diff_in,
    input  logic [shift_w-1:0]        lr_shift,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [size*data_size-1:0] weight_out,
    output logic [idx_w-1:0]          idx
);

    state_e                state_q, state_d;
    logic [data_size-1:0]  w_q    [size];
    logic [data_size-1:0]  w_d    [size];
    logic [data_size-1:0]  dbuf_q [size];
    logic [shift_w-1:0]    lr_q;
    logic [idx_w-1:0]      idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  load, accept, last;
    logic [data_size-1:0]  upd;

    // load has priority over start when both arrive in IDLE
    assign load   = (state_q == IDLE) && load_en;
    assign accept = (state_q == IDLE) && start && !load_en;
    assign last   = (idx_q == idx_w'(size - 1));

    sat_sub_unit #(
        .data_size(data_size),
        .shift_w  (shift_w)
    ) u_sat (
        .a    (w_q[idx_q]),
        .b    (dbuf_q[idx_q]),
        .shift(lr_q),
        .y    (upd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CAPTURE;
            CAPTURE: state_d = UPDATE;
            UPDATE:  if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        idx_d  = idx_q;
        unique case (state_q)
            CAPTURE: idx_d = '0;
            UPDATE:  if (!last) idx_d = idx_q + 1'b1;
            DONE:    idx_d = '0;
            default: idx_d = idx_q;
        endcase
    end

    always_comb begin
        for (int i = 0; i < size; i++) begin
            w_d[i] = w_q[i];
        end
        if (load) begin
            for (int i = 0; i < size; i++) begin
                w_d[i] = weight_in[i*data_size +: data_size];
            end
        end else if (state_q == UPDATE) begin
            w_d[idx_q] = upd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < size; i++) begin
                w_q[i]    <= '0;
                dbuf_q[i] <= '0;
            end
            lr_q <= '0;
        end else begin
            for (int i = 0; i < size; i++) begin
                w_q[i] <= w_d[i];
            end
            if (state_q == CAPTURE) begin
                for (int i = 0; i < size; i++) begin
                    dbuf_q[i] <= diff_in[i*data_size +: data_size];
                end
            end
            if (accept) begin
                lr_q <= lr_shift;
            end
        end
    end

    for (genvar g = 0; g < size; g++) begin : g_out
        assign weight_out[g*data_size +: data_size] = w_q[g];
    end

    assign busy = busy_q;
    assign done = done_q;
    assign idx  = idx_q;

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Self-checking bench for weight_update_sequencer (size=3, data_size=16)
// against an integer-arithmetic model of the update rule.
module tb_weight_update_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [47:0] weight_in;
    logic [47:0] diff_in;
    logic [3:0]  lr_shift;
    logic        start;
    logic        busy;
    logic        done;
    logic [47:0] weight_out;
    logic [1:0]  idx;

    int checks;
    int errors;
    int mw [3];

    weight_update_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .weight_in (weight_in),
        .diff_in   (diff_in),
        .lr_shift  (lr_shift),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .weight_out(weight_out),
        .idx       (idx)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pack3(input int a, input int b, input int c);
        logic [15:0] x, y, z;
        x = a[15:0];
        y = b[15:0];
        z = c[15:0];
        return {z, y, x};
    endfunction

    function automatic logic [47:0] model_vec();
        return pack3(mw[0], mw[1], mw[2]);
    endfunction

    function automatic int rnd16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    // floor(d / 2^lr), then clamp to the 16-bit signed range
    function automatic int model_step(input int w, input int d, input int lr);
        int s, r, p;
        if (lr >= 16) begin
            s = (d < 0) ? -1 : 0;
        end else begin
            p = 1 << lr;
            if (d >= 0) s = d / p;
            else        s = -((-d + p - 1) / p);
        end
        r = w - s;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic do_load(input int a, input int b, input int c);
        @(negedge clk);
        load_en   = 1'b1;
        weight_in = pack3(a, b, c);
        @(negedge clk);
        load_en = 1'b0;
        mw[0] = a;
        mw[1] = b;
        mw[2] = c;
    endtask

    task automatic run_pass(input int d0, input int d1, input int d2,
                            input int lr, input bit disturb,
                            output int ndone, output int done_at,
                            output int nbusy);
        @(negedge clk);
        start    = 1'b1;
        diff_in  = pack3(d0, d1, d2);
        lr_shift = 4'(lr);
        ndone    = 0;
        done_at  = -1;
        nbusy    = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                done_at = j;
            end
            if (j == 0) start = 1'b0;
            if (disturb && j == 1) begin
                start     = 1'b1;
                load_en   = 1'b1;
                weight_in = pack3(rnd16(), rnd16(), rnd16());
                diff_in   = pack3(rnd16(), rnd16(), rnd16());
                lr_shift  = 4'($urandom_range(0, 15));
            end
            if (disturb && j == 3) begin
                start   = 1'b0;
                load_en = 1'b0;
            end
        end
        mw[0] = model_step(mw[0], d0, lr);
        mw[1] = model_step(mw[1], d1, lr);
        mw[2] = model_step(mw[2], d2, lr);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (weight_out !== 48'd0 || busy !== 1'b0 || done !== 1'b0 || idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_init: w=%h busy=%b done=%b idx=%0d, want 0", weight_out, busy, done, idx);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mw = '{0, 0, 0};
    endtask

    task automatic test_reset_mid();
        do_load(100, -50, 7);
        @(negedge clk);
        start    = 1'b1;
        diff_in  = pack3(40, -8, 3);
        lr_shift = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (weight_out !== 48'd0 || busy !== 1'b0 || done !== 1'b0 || idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: w=%h busy=%b done=%b idx=%0d, want 0", weight_out, busy, done, idx);
        end
        @(negedge clk);
        rst = 1'b0;
        mw = '{0, 0, 0};
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_load();
        do_load(100, -50, 7);
        checks++;
        if (weight_out !== pack3(100, -50, 7)) begin
            errors++;
            $display("FAIL load: w=%h, want %h", weight_out, pack3(100, -50, 7));
        end
    endtask

    task automatic test_basic();
        int nd, da, nb;
        do_load(100, -50, 7);
        run_pass(40, -8, 3, 2, 1'b0, nd, da, nb);
        checks++;
        if (nb !== 5) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want 5", nb);
        end
        checks++;
        if (nd !== 1 || da !== 4) begin
            errors++;
            $display("FAIL basic_done: count=%0d at=%0d, want 1 at 4", nd, da);
        end
        checks++;
        if (weight_out !== pack3(90, -48, 7)) begin
            errors++;
            $display("FAIL basic_weights: w=%h, want %h", weight_out, pack3(90, -48, 7));
        end
        checks++;
        if (weight_out !== model_vec()) begin
            errors++;
            $display("FAIL basic_model: w=%h, want %h", weight_out, model_vec());
        end
        checks++;
        if (idx !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: idx=%0d busy=%b, want 0 0", idx, busy);
        end
    endtask

    task automatic test_saturation();
        int nd, da, nb;
        do_load(32760, -32760, 5);
        run_pass(-64, 64, -1, 0, 1'b0, nd, da, nb);
        checks++;
        if (weight_out !== pack3(32767, -32768, 6)) begin
            errors++;
            $display("FAIL sat_clamp: w=%h, want %h", weight_out, pack3(32767, -32768, 6));
        end
        run_pass(0, 0, -1, 15, 1'b0, nd, da, nb);
        checks++;
        if (weight_out !== pack3(32767, -32768, 7)) begin
            errors++;
            $display("FAIL sat_shift15: w=%h, want %h", weight_out, pack3(32767, -32768, 7));
        end
        checks++;
        if (weight_out !== model_vec()) begin
            errors++;
            $display("FAIL sat_model: w=%h, want %h", weight_out, model_vec());
        end
    endtask

    task automatic test_ignored_inputs();
        int nd, da, nb;
        do_load(1234, -4321, 999);
        run_pass(300, -700, 12, 3, 1'b1, nd, da, nb);
        checks++;
        if (nd !== 1 || da !== 4 || nb !== 5) begin
            errors++;
            $display("FAIL ignored_timing: done=%0d at=%0d busy=%0d, want 1 4 5", nd, da, nb);
        end
        checks++;
        if (weight_out !== model_vec()) begin
            errors++;
            $display("FAIL ignored_weights: w=%h, want %h", weight_out, model_vec());
        end
    endtask

    task automatic test_start_load();
        int nb, nd;
        do_load(1, 2, 3);
        @(negedge clk);
        start     = 1'b1;
        load_en   = 1'b1;
        weight_in = pack3(11, 22, 33);
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        mw = '{11, 22, 33};
        checks++;
        if (weight_out !== model_vec()) begin
            errors++;
            $display("FAIL start_load_weights: w=%h, want %h", weight_out, model_vec());
        end
        nb = 0;
        nd = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        checks++;
        if (nb !== 0 || nd !== 0) begin
            errors++;
            $display("FAIL start_load_nopass: busy=%0d done=%0d, want 0 0", nb, nd);
        end
    endtask

    task automatic test_back_to_back();
        int prev, nd;
        do_load(1000, -1000, 0);
        @(negedge clk);
        start    = 1'b1;
        diff_in  = pack3(100, -100, 17);
        lr_shift = 4'd1;
        prev = -2;
        nd   = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done) begin
                for (int i = 0; i < 3; i++) begin
                    mw[i] = model_step(mw[i], (i == 0) ? 100 : (i == 1) ? -100 : 17, 1);
                end
                checks++;
                if ((nd == 0 && j !== 4) || (nd > 0 && j - prev !== 6)) begin
                    errors++;
                    $display("FAIL b2b_period: done at %0d prev %0d", j, prev);
                end
                checks++;
                if (weight_out !== model_vec()) begin
                    errors++;
                    $display("FAIL b2b_weights: w=%h, want %h", weight_out, model_vec());
                end
                prev = j;
                nd++;
            end
            if (j == 17) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle_gap: busy=%b, want 0", busy);
                end
            end
        end
        checks++;
        if (nd !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d, want 3", nd);
        end
    endtask

    task automatic test_random();
        int nd, da, nb;
        int d0, d1, d2, lr;
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 2) == 0) do_load(rnd16(), rnd16(), rnd16());
            d0 = rnd16();
            d1 = rnd16();
            d2 = rnd16();
            lr = int'($urandom_range(0, 15));
            run_pass(d0, d1, d2, lr, 1'($urandom_range(0, 1)), nd, da, nb);
            checks++;
            if (weight_out !== model_vec() || nd !== 1 || da !== 4) begin
                errors++;
                $display("FAIL random_%0d: w=%h done=%0d at=%0d, want %h 1 4",
                         k, weight_out, nd, da, model_vec());
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        load_en   = 1'b0;
        start     = 1'b0;
        weight_in = '0;
        diff_in   = '0;
        lr_shift  = '0;
        test_reset();
        test_reset_mid();
        test_load();
        test_basic();
        test_saturation();
        test_ignored_inputs();
        test_start_load();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
